// File: rtl/wb_initiator.sv
// Wishbone pipelined-mode initiator: single-beat valid/ready requests in,
// pipelined strobes out, one in-order response per ack.
//
// Optional watchdog abort: define WB_TIMEOUT_EN to enable it.
//
// Parameters
//   MAX_TXN  accepted-but-unacked transaction limit (1..15)
//   TIMEOUT  idle cycles with work outstanding before abort (WB_TIMEOUT_EN)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_addr/req_data/req_we       request payload
//   rsp_valid/rsp_data/rsp_we      one-cycle response pulse, no backpressure
//   rsp_err                        response is a timeout abort
//   busy                           cycle open or transactions outstanding
//   wb_addr/wb_data_w/wb_we        registered bus request fields
//   wb_stb/wb_cyc                  registered bus strobe / cycle
//   wb_data_r/wb_ack/wb_stall      slave read data, acknowledge, stall
module wb_initiator #(
    parameter int MAX_TXN = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_we,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_we,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_data_w,
    input  logic [31:0] wb_data_r,
    output logic        wb_we,
    output logic        wb_stb,
    output logic        wb_cyc,
    input  logic        wb_ack,
    input  logic        wb_stall
);

    localparam int PW = (MAX_TXN > 1) ? $clog2(MAX_TXN) : 1;

`ifdef WB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_ABORT} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_BUS} state_e;
`endif

    state_e            state_q;
    logic [3:0]        outstanding_q;
    logic [3:0]        outstanding_d;
    logic [MAX_TXN-1:0] fifo_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;

    logic [31:0]       wb_addr_q;
    logic [31:0]       wb_data_w_q;
    logic              wb_we_q;
    logic              wb_stb_q;
    logic              wb_cyc_q;

    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_we_q;

    logic              stall_ok;
    logic              not_abort;
    logic              accept;
    logic              ack_v;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_TXN - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef WB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wdog_q;
    logic [WW-1:0] wdog_d;
    logic          timeout;
    logic          rsp_err_q;

    assign not_abort = (state_q != S_ABORT);

    always_comb begin
        wdog_d = '0;
        if (!accept && !ack_v && outstanding_q != 4'd0) begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    // An accept or ack in the expiry cycle counts as progress.
    assign timeout = (state_q == S_BUS) && (wdog_q == WW'(TIMEOUT))
                     && !accept && !ack_v;
    assign rsp_err = rsp_err_q;
`else
    assign not_abort = 1'b1;
    assign rsp_err   = 1'b0;
`endif

    // Ready never looks at wb_ack; a freed slot shows up a cycle later.
    assign stall_ok  = !wb_stb_q || !wb_stall;
    assign req_ready = !rst && not_abort && stall_ok
                       && (outstanding_q < 4'(MAX_TXN));
    assign accept    = req_valid && req_ready;
    assign ack_v     = wb_ack && wb_cyc_q;

    assign outstanding_d = outstanding_q + 4'(accept) - 4'(ack_v);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            outstanding_q <= '0;
            fifo_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            wb_addr_q     <= '0;
            wb_data_w_q   <= '0;
            wb_we_q       <= 1'b0;
            wb_stb_q      <= 1'b0;
            wb_cyc_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_we_q      <= 1'b0;
`ifdef WB_TIMEOUT_EN
            rsp_err_q     <= 1'b0;
            wdog_q        <= '0;
`endif
        end else begin
            rsp_valid_q   <= ack_v;
            outstanding_q <= outstanding_d;
`ifdef WB_TIMEOUT_EN
            rsp_err_q     <= 1'b0;
            wdog_q        <= wdog_d;
`endif
            if (ack_v) begin
                rsp_data_q <= wb_data_r;
                rsp_we_q   <= fifo_q[rd_ptr_q];
                rd_ptr_q   <= ptr_inc(rd_ptr_q);
            end

            // Accept is only possible when the current strobe is not stalled,
            // so a held request is never overwritten.
            if (accept) begin
                wb_addr_q        <= req_addr;
                wb_data_w_q      <= req_data;
                wb_we_q          <= req_we;
                wb_stb_q         <= 1'b1;
                fifo_q[wr_ptr_q] <= req_we;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end else if (wb_stb_q && !wb_stall) begin
                wb_stb_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q  <= S_BUS;
                        wb_cyc_q <= 1'b1;
                    end
                end
                S_BUS: begin
`ifdef WB_TIMEOUT_EN
                    if (timeout) begin
                        state_q       <= S_ABORT;
                        wb_cyc_q      <= 1'b0;
                        wb_stb_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_we_q      <= fifo_q[rd_ptr_q];
                        outstanding_q <= '0;
                        rd_ptr_q      <= '0;
                        wr_ptr_q      <= '0;
                        wdog_q        <= '0;
                    end else
`endif
                    if (outstanding_d == 4'd0 && !accept) begin
                        state_q  <= S_IDLE;
                        wb_cyc_q <= 1'b0;
                    end
                end
`ifdef WB_TIMEOUT_EN
                S_ABORT: begin
                    state_q <= S_IDLE;
                end
`endif
                default: begin
                    state_q  <= S_IDLE;
                    wb_cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = wb_cyc_q || (outstanding_q != 4'd0);
    assign wb_addr   = wb_addr_q;
    assign wb_data_w = wb_data_w_q;
    assign wb_we     = wb_we_q;
    assign wb_stb    = wb_stb_q;
    assign wb_cyc    = wb_cyc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_we    = rsp_we_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: vector table for the main flows,
// hand sequences for reset mid-burst and (optionally) the watchdog.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_we;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_we;
    logic        rsp_err;
    logic        busy;
    logic [31:0] wb_addr;
    logic [31:0] wb_data_w;
    logic [31:0] wb_data_r;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;
    logic        wb_stall;

    always #5 clk = ~clk;

    wb_initiator #(.MAX_TXN(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_we    (req_we),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_we    (rsp_we),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .wb_addr   (wb_addr),
        .wb_data_w (wb_data_w),
        .wb_data_r (wb_data_r),
        .wb_we     (wb_we),
        .wb_stb    (wb_stb),
        .wb_cyc    (wb_cyc),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        ack;
        logic        stall;
        logic [31:0] dr;
        logic        e_rdy;
        logic        e_stb;
        logic        e_cyc;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_rwe;
        logic        e_busy;
    } vec_t;

    localparam int NV = 26;
    vec_t tv[NV];

    function automatic vec_t mk(
        input logic v, input logic [31:0] a, input logic [31:0] d,
        input logic we, input logic ack, input logic stall,
        input logic [31:0] dr, input logic e_rdy, input logic e_stb,
        input logic e_cyc, input logic [31:0] e_addr, input logic e_we,
        input logic [31:0] e_wd, input logic e_rv, input logic [31:0] e_rd,
        input logic e_rwe, input logic e_busy);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.we = we; r.ack = ack;
        r.stall = stall; r.dr = dr; r.e_rdy = e_rdy; r.e_stb = e_stb;
        r.e_cyc = e_cyc; r.e_addr = e_addr; r.e_we = e_we; r.e_wd = e_wd;
        r.e_rv = e_rv; r.e_rd = e_rd; r.e_rwe = e_rwe; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_we    = 1'b0;
        wb_ack    = 1'b0;
        wb_stall  = 1'b0;
        wb_data_r = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single write: stb 1 cycle, cyc 2 cycles.
        tv[0]  = mk(1'b1, 32'h10, 32'hAB, 1'b1, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hAB, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[1]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'hAB, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[2]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hC0DE,
                    1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'hAB, 1'b1, 32'hC0DE, 1'b1, 1'b0);
        tv[3]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'hAB, 1'b0, 32'h0, 1'b0, 1'b0);
        // Three reads, first strobe stalled two cycles.
        tv[4]  = mk(1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[5]  = mk(1'b1, 32'h104, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0,
                    1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[6]  = mk(1'b1, 32'h104, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0,
                    1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[7]  = mk(1'b1, 32'h104, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[8]  = mk(1'b1, 32'h108, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11111111,
                    1'b1, 1'b1, 1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0, 1'b1);
        tv[9]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h22222222,
                    1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 32'h22222222, 1'b0, 1'b1);
        tv[10] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h33333333,
                    1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 32'h0, 1'b1, 32'h33333333, 1'b0, 1'b0);
        tv[11] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        // Fill to MAX_TXN, fifth waits for the first ack.
        tv[12] = mk(1'b1, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[13] = mk(1'b1, 32'h204, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[14] = mk(1'b1, 32'h208, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h208, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[15] = mk(1'b1, 32'h20C, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h20C, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[16] = mk(1'b1, 32'h210, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h20C, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[17] = mk(1'b1, 32'h210, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA0,
                    1'b0, 1'b0, 1'b1, 32'h20C, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b0, 1'b1);
        tv[18] = mk(1'b1, 32'h210, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h210, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[19] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA1,
                    1'b0, 1'b0, 1'b1, 32'h210, 1'b0, 32'h0, 1'b1, 32'hA1, 1'b0, 1'b1);
        tv[20] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA2,
                    1'b1, 1'b0, 1'b1, 32'h210, 1'b0, 32'h0, 1'b1, 32'hA2, 1'b0, 1'b1);
        tv[21] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA3,
                    1'b1, 1'b0, 1'b1, 32'h210, 1'b0, 32'h0, 1'b1, 32'hA3, 1'b0, 1'b1);
        tv[22] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA4,
                    1'b1, 1'b0, 1'b0, 32'h210, 1'b0, 32'h0, 1'b1, 32'hA4, 1'b0, 1'b0);
        // Accept and ack together with one outstanding: cyc stays up.
        tv[23] = mk(1'b1, 32'h300, 32'h55, 1'b1, 1'b0, 1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h55, 1'b0, 32'h0, 1'b0, 1'b1);
        tv[24] = mk(1'b1, 32'h304, 32'h0, 1'b0, 1'b1, 1'b0, 32'hB0,
                    1'b1, 1'b1, 1'b1, 32'h304, 1'b0, 32'h0, 1'b1, 32'hB0, 1'b1, 1'b1);
        tv[25] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hB1,
                    1'b1, 1'b0, 1'b0, 32'h304, 1'b0, 32'h0, 1'b1, 32'hB1, 1'b0, 1'b0);

        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_cyc", {31'b0, wb_cyc}, 32'h0);
        chk("rst_stb", {31'b0, wb_stb}, 32'h0);
        chk("rst_we", {31'b0, wb_we}, 32'h0);
        chk("rst_addr", wb_addr, 32'h0);
        chk("rst_wdata", wb_data_w, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            req_valid = tv[i].v;
            req_addr  = tv[i].a;
            req_data  = tv[i].d;
            req_we    = tv[i].we;
            wb_ack    = tv[i].ack;
            wb_stall  = tv[i].stall;
            wb_data_r = tv[i].dr;
            #2;
            chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, {31'b0, tv[i].e_rdy});
            tick();
            chk($sformatf("v%0d_stb", i), {31'b0, wb_stb}, {31'b0, tv[i].e_stb});
            chk($sformatf("v%0d_cyc", i), {31'b0, wb_cyc}, {31'b0, tv[i].e_cyc});
            chk($sformatf("v%0d_addr", i), wb_addr, tv[i].e_addr);
            chk($sformatf("v%0d_we", i), {31'b0, wb_we}, {31'b0, tv[i].e_we});
            chk($sformatf("v%0d_wdata", i), wb_data_w, tv[i].e_wd);
            chk($sformatf("v%0d_rsp_valid", i), {31'b0, rsp_valid}, {31'b0, tv[i].e_rv});
            chk($sformatf("v%0d_rsp_err", i), {31'b0, rsp_err}, 32'h0);
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, tv[i].e_busy});
            if (tv[i].e_rv) begin
                chk($sformatf("v%0d_rsp_data", i), rsp_data, tv[i].e_rd);
                chk($sformatf("v%0d_rsp_we", i), {31'b0, rsp_we}, {31'b0, tv[i].e_rwe});
            end
        end
        idle_inputs();

        // Reset with two reads outstanding, then a late ack.
        req_valid = 1'b1;
        req_addr  = 32'h400;
        tick();
        req_addr  = 32'h404;
        tick();
        chk("mid_busy", {31'b0, busy}, 32'h1);
        chk("mid_cyc", {31'b0, wb_cyc}, 32'h1);
        req_valid = 1'b0;
        rst       = 1'b1;
        wb_ack    = 1'b1;
        wb_data_r = 32'hDEAD;
        #1;
        chk("mid_rst_ready", {31'b0, req_ready}, 32'h0);
        tick();
        chk("mid_rst_cyc", {31'b0, wb_cyc}, 32'h0);
        chk("mid_rst_stb", {31'b0, wb_stb}, 32'h0);
        chk("mid_rst_rsp", {31'b0, rsp_valid}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        tick();
        chk("late_ack_rsp", {31'b0, rsp_valid}, 32'h0);
        chk("late_ack_cyc", {31'b0, wb_cyc}, 32'h0);
        chk("late_ack_busy", {31'b0, busy}, 32'h0);
        idle_inputs();
        tick();

`ifdef WB_TIMEOUT_EN
        begin
            int rv_cnt;
            rv_cnt    = 0;
            req_valid = 1'b1;
            req_addr  = 32'h500;
            tick();
            req_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (rsp_valid) rv_cnt++;
            end
            chk("to_early_rsp", 32'(rv_cnt), 32'h0);
            chk("to_wait_cyc", {31'b0, wb_cyc}, 32'h1);
            tick();
            chk("to_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("to_rsp_err", {31'b0, rsp_err}, 32'h1);
            chk("to_rsp_data", rsp_data, 32'h0);
            chk("to_cyc", {31'b0, wb_cyc}, 32'h0);
            chk("to_stb", {31'b0, wb_stb}, 32'h0);
            chk("to_abort_ready", {31'b0, req_ready}, 32'h0);
            tick();
            chk("to_after_rsp", {31'b0, rsp_valid}, 32'h0);
            chk("to_after_busy", {31'b0, busy}, 32'h0);
            chk("to_after_ready", {31'b0, req_ready}, 32'h1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
